// File: rtl/short_long_classifier_if.sv
// Bundles the button inputs and classified press outputs of short_long_classifier.
//   btn          : raw button levels, 1 = pressed (master -> slave)
//   ch_en        : per-channel enable (master -> slave)
//   press_short  : one-cycle pulse on release of a short press (slave -> master)
//   press_long   : one-cycle pulse when a hold reaches the long threshold
//   press_repeat : one-cycle auto-repeat pulses while a long press is held
//   held         : level, channel is in a press (PRESS or LONG)
//   event_any    : OR of all pulse outputs of the same cycle
interface short_long_classifier_if #(
  parameter int unsigned N_CH = 4
) ();
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] ch_en;
  logic [N_CH-1:0] press_short;
  logic [N_CH-1:0] press_long;
  logic [N_CH-1:0] press_repeat;
  logic [N_CH-1:0] held;
  logic            event_any;

  modport master (
    output btn, ch_en,
    input  press_short, press_long, press_repeat, held, event_any
  );

  modport slave (
    input  btn, ch_en,
    output press_short, press_long, press_repeat, held, event_any
  );
endinterface

// File: rtl/short_long_classifier.sv
// Multi-channel short/long button press classifier with optional auto-repeat.
// Each channel samples its button on every clk_1Hz rising edge and runs an
// IDLE/PRESS/LONG state machine. All outputs are registered and change on the
// same edge as the channel state.
//   clk_1Hz : system clock, rising edge
//   rst     : asynchronous, active-high reset (discards any press in progress)
//   bus     : short_long_classifier_if slave (btn, ch_en in; pulses, held,
//             event_any out)
module short_long_classifier #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned LONG_CYC   = 3,
  parameter int unsigned REPEAT_CYC = 2,
  parameter int unsigned REPEAT_EN  = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                     clk_1Hz,
  input  logic                     rst,
  short_long_classifier_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  // Comparing against threshold-1 is the same as "cnt+1 == threshold"
  // without needing a wider adder.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state [N_CH];
  logic [CNT_W-1:0] r_cnt   [N_CH];
  state_t           w_state_nx [N_CH];
  logic [CNT_W-1:0] w_cnt_nx   [N_CH];

  logic [N_CH-1:0] w_short, w_long, w_rep, w_held;
  logic [N_CH-1:0] r_short, r_long, r_rep, r_held;
  logic            r_event_any;

  always_comb begin
    w_short = '0;
    w_long  = '0;
    w_rep   = '0;
    w_held  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_state_nx[i] = r_state[i];
      w_cnt_nx[i]   = r_cnt[i];
      if (!bus.ch_en[i]) begin
        w_state_nx[i] = IDLE;
        w_cnt_nx[i]   = '0;
      end else begin
        unique case (r_state[i])
          IDLE: begin
            if (bus.btn[i]) begin
              w_state_nx[i] = PRESS;
              w_cnt_nx[i]   = CNT_ONE;
            end
          end
          PRESS: begin
            if (bus.btn[i]) begin
              if (r_cnt[i] == LONG_LAST) begin
                w_state_nx[i] = LONG;
                w_cnt_nx[i]   = '0;
                w_long[i]     = 1'b1;
              end else begin
                w_cnt_nx[i] = r_cnt[i] + CNT_ONE;
              end
            end else begin
              w_state_nx[i] = IDLE;
              w_cnt_nx[i]   = '0;
              w_short[i]    = 1'b1;
            end
          end
          LONG: begin
            if (bus.btn[i]) begin
              if ((REPEAT_EN != 0) && (r_cnt[i] == REP_LAST)) begin
                w_cnt_nx[i] = '0;
                w_rep[i]    = 1'b1;
              end else if ((REPEAT_EN != 0) || (r_cnt[i] != CNT_MAX)) begin
                w_cnt_nx[i] = r_cnt[i] + CNT_ONE;
              end
            end else begin
              w_state_nx[i] = IDLE;
              w_cnt_nx[i]   = '0;
            end
          end
          default: begin
            w_state_nx[i] = IDLE;
            w_cnt_nx[i]   = '0;
          end
        endcase
      end
      w_held[i] = (w_state_nx[i] != IDLE);
    end
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
      end
      r_short     <= '0;
      r_long      <= '0;
      r_rep       <= '0;
      r_held      <= '0;
      r_event_any <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_state[i] <= w_state_nx[i];
        r_cnt[i]   <= w_cnt_nx[i];
      end
      r_short     <= w_short;
      r_long      <= w_long;
      r_rep       <= w_rep;
      r_held      <= w_held;
      r_event_any <= |(w_short | w_long | w_rep);
    end
  end

  assign bus.press_short  = r_short;
  assign bus.press_long   = r_long;
  assign bus.press_repeat = r_rep;
  assign bus.held         = r_held;
  assign bus.event_any    = r_event_any;

endmodule

// File: doc/short_long_classifier.md
Name: short_long_classifier

Overview:
- Multi-channel, parametrised successor to the single-input short/long press detector.
- Each channel samples one button level on every clk_1Hz edge and classifies each press.
- Short press: released before a hold threshold. Long press: held to the threshold.
- An optional auto-repeat pulse train is produced while a long press is still held.
- Sits between the button inputs and the clock-setting control logic; it replaces per-button inc_short/inc_long pairs.

Parameters:
- N_CH, 4, number of independent button channels (≥1).
- LONG_CYC, 3, consecutive high samples that make a press long (≥2).
- REPEAT_CYC, 2, cycles between repeat pulses after the long pulse (≥1).
- REPEAT_EN, 1, 1 = generate repeat pulses, 0 = never assert press_repeat.
- CNT_W, 4, per-channel counter width; must satisfy LONG_CYC and REPEAT_CYC ≤ 2^CNT_W−1.

Ports:
- clk_1Hz  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn  in  N_CH  raw button levels, synchronous to clk_1Hz; 1 = pressed.
- ch_en  in  N_CH  per-channel enable.
- press_short  out  N_CH  one-cycle pulse on release of a short press.
- press_long  out  N_CH  one-cycle pulse when the hold reaches LONG_CYC.
- press_repeat  out  N_CH  one-cycle pulses while a long press is held.
- held  out  N_CH  level: channel state ≠ IDLE.
- event_any  out  1  registered OR of all pulse outputs in the same cycle.

Behaviour:
- Reset, asynchronous, while rst=1:
  - every channel goes to IDLE with cnt=0;
  - all outputs are 0;
  - a mid-press reset discards the press with no pulse emitted.
- After reset release, a btn still high counts as a new press from the first sampled edge.
- Per-channel FSM. States: IDLE, PRESS, LONG. All outputs are registered and update on the same edge as the state.
  - IDLE, btn=1 → PRESS, cnt=1. IDLE, btn=0 → stay.
  - PRESS, btn=1:
    - if cnt+1 == LONG_CYC → LONG, cnt=0, press_long=1 for one cycle;
    - else cnt=cnt+1.
  - PRESS, btn=0 → IDLE, press_short=1 for one cycle.
  - LONG, btn=1:
    - if REPEAT_EN and cnt+1 == REPEAT_CYC → cnt=0, press_repeat=1 for one cycle;
    - else cnt=cnt+1, saturating at 2^CNT_W−1 when REPEAT_EN=0.
  - LONG, btn=0 → IDLE. No pulse is emitted on a long release.
- Resulting press classification:
  - k consecutive high samples with 1 ≤ k < LONG_CYC, then a low sample → exactly one press_short, on the edge that sampled the low.
  - High samples reaching k = LONG_CYC → press_long asserted after the LONG_CYC-th high edge.
  - First press_repeat comes REPEAT_CYC edges after press_long, then every REPEAT_CYC edges.
- Pulse exclusivity:
  - press_short, press_long and press_repeat are mutually exclusive per channel per cycle.
  - A pulse is never longer than one cycle.
- ch_en:
  - ch_en[i]=0 forces channel i to IDLE, cnt=0, on the next edge; outputs for that channel are 0 in that cycle.
  - A press in progress is discarded silently.
  - Re-enabling while btn high starts a new press at the next edge.
- Channels are fully independent. Simultaneous events on several channels all appear in the same cycle; event_any is 1 if any channel pulses.
- held[i] = 1 in PRESS and LONG, 0 in IDLE. It is registered, so it aligns with the state.
- Glitch of exactly one high sample (k=1) with LONG_CYC ≥ 2 is a short press.

Test Plan:
- Use the default parameters and a 10-time-unit clock period.
- Short press: btn[0] high for 2 edges, then low → press_short[0] one pulse on the 3rd edge; press_long and press_repeat stay 0; held[0] high for 2 cycles.
- Long with repeat: btn[1] high for 10 edges → press_long[1] after edge 3; press_repeat[1] after edges 5, 7, 9; on release no press_short, held[1] falls.
- Boundary: btn[2] high for exactly 3 edges then low → press_long only, no press_short. 2 edges then low → press_short only.
- Concurrent channels: btn[0] short (1 edge) and btn[3] long, overlapping → pulses on the correct channels in the same cycles; event_any matches the OR of the pulses.
- Reset mid-press: assert rst during LONG on ch1 → outputs 0 immediately. Release rst with btn still high → press_long 3 edges later, and no pulse for the aborted press.
- ch_en and REPEAT_EN=0 build:
  - drop ch_en[2] during PRESS → no pulse;
  - with REPEAT_EN=0, hold 20 edges → a single press_long and no press_repeat.
